// File: rtl/multicycle_control_unit.sv
// Main-control FSM for the multicycle MIPS datapath.
// One instruction step per clock; control strobes are decoded from the current
// state so they change in the same cycle as the state, and reset clears them
// in the cycle it is asserted so a partially executed instruction never writes.
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 PCen,
    output logic                 IorD,
    output logic                 Ori,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [2:0]           ALUControl,
    output logic                 Jump,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEXEC  = 4'd9,
        S_IMMWB    = 4'd10,
        S_GPIOEXEC = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_IN   = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       ori;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [2:0] aluctl;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   funct_legal_s;
    logic [2:0]             alu_funct_s;
    logic                   decode_illegal_s;
    ctrl_t                  ctrl_s;

    // R-type funct decode: legality and the ALU operation it selects
    always_comb begin
        funct_legal_s = 1'b1;
        alu_funct_s   = ALU_ADD;
        case (funct)
            F_ADD:   alu_funct_s = ALU_ADD;
            F_SUB:   alu_funct_s = ALU_SUB;
            F_AND:   alu_funct_s = ALU_AND;
            F_OR:    alu_funct_s = ALU_OR;
            F_NOR:   alu_funct_s = ALU_NOR;
            F_SLT:   alu_funct_s = ALU_SLT;
            F_JR:    alu_funct_s = ALU_ADD;
            default: funct_legal_s = 1'b0;
        endcase
    end

    // Next-state selection; op/funct come from the IR and stay stable after FETCH
    always_comb begin
        next_state_s     = S_FETCH;
        decode_illegal_s = 1'b0;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   next_state_s = S_MEMADR;
                    OP_R: begin
                        if (!funct_legal_s) begin
                            next_state_s     = S_FETCH;
                            decode_illegal_s = 1'b1;
                        end else if (funct == F_JR) begin
                            next_state_s = S_JR;
                        end else begin
                            next_state_s = S_EXECUTE;
                        end
                    end
                    OP_BEQ, OP_BNE:  next_state_s = S_BRANCH;
                    OP_ADDI, OP_ORI: next_state_s = S_IMMEXEC;
                    OP_IN:           next_state_s = S_GPIOEXEC;
                    OP_J:            next_state_s = S_JUMP;
                    OP_JAL:          next_state_s = S_JAL;
                    default: begin
                        next_state_s     = S_FETCH;
                        decode_illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    next_state_s = S_MEMWRITE;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTE:  next_state_s = S_ALUWB;
            S_IMMEXEC:  next_state_s = S_IMMWB;
            S_GPIOEXEC: next_state_s = S_IMMWB;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter (a return to FETCH from an
    // execution state marks a completed instruction; illegal ops leave from DECODE)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            count_r <= '0;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_DECODE)) begin
                count_r <= count_r + CNT_WIDTH'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Control decode from the current state, forced to zero while reset is high
    always_comb begin
        ctrl_s = '0;
        if (reset) begin
            ctrl_s = '0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    ctrl_s.irwrite = 1'b1;
                    ctrl_s.alusrcb = 2'b01;
                    ctrl_s.aluctl  = ALU_ADD;
                    ctrl_s.pcen    = 1'b1;
                end
                S_DECODE: begin
                    ctrl_s.alusrcb = 2'b11;
                    ctrl_s.aluctl  = ALU_ADD;
                    ctrl_s.illegal = decode_illegal_s;
                end
                S_MEMADR: begin
                    ctrl_s.alusrca = 1'b1;
                    ctrl_s.alusrcb = 2'b10;
                    ctrl_s.aluctl  = ALU_ADD;
                end
                S_MEMREAD: ctrl_s.iord = 1'b1;
                S_MEMWB: begin
                    ctrl_s.iord     = 1'b1;
                    ctrl_s.regdst   = 2'b00;
                    ctrl_s.memtoreg = 2'b01;
                    ctrl_s.regwrite = 1'b1;
                end
                S_MEMWRITE: begin
                    ctrl_s.iord     = 1'b1;
                    ctrl_s.memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl_s.alusrca = 1'b1;
                    ctrl_s.alusrcb = 2'b00;
                    ctrl_s.aluctl  = alu_funct_s;
                end
                S_ALUWB: begin
                    ctrl_s.regdst   = 2'b01;
                    ctrl_s.memtoreg = 2'b00;
                    ctrl_s.regwrite = 1'b1;
                end
                S_BRANCH: begin
                    ctrl_s.alusrca = 1'b1;
                    ctrl_s.alusrcb = 2'b00;
                    ctrl_s.aluctl  = ALU_SUB;
                    ctrl_s.pcsrc   = 2'b01;
                    ctrl_s.pcen    = (op == OP_BNE) ? ~zero : zero;
                end
                S_IMMEXEC: begin
                    ctrl_s.alusrca = 1'b1;
                    ctrl_s.alusrcb = 2'b10;
                    ctrl_s.aluctl  = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                end
                S_IMMWB: begin
                    ctrl_s.regdst   = 2'b00;
                    ctrl_s.memtoreg = 2'b00;
                    ctrl_s.regwrite = 1'b1;
                end
                S_GPIOEXEC: begin
                    ctrl_s.ori     = 1'b1;
                    ctrl_s.alusrca = 1'b1;
                    ctrl_s.alusrcb = 2'b10;
                    ctrl_s.aluctl  = ALU_ADD;
                end
                S_JUMP: begin
                    ctrl_s.pcsrc = 2'b10;
                    ctrl_s.jump  = 1'b1;
                    ctrl_s.pcen  = 1'b1;
                end
                S_JAL: begin
                    ctrl_s.pcsrc    = 2'b10;
                    ctrl_s.jump     = 1'b1;
                    ctrl_s.pcen     = 1'b1;
                    ctrl_s.regdst   = 2'b10;
                    ctrl_s.memtoreg = 2'b10;
                    ctrl_s.regwrite = 1'b1;
                end
                S_JR: begin
                    ctrl_s.pcsrc = 2'b11;
                    ctrl_s.pcen  = 1'b1;
                end
                default: ctrl_s = '0;
            endcase
        end
    end

    assign PCen        = ctrl_s.pcen;
    assign IorD        = ctrl_s.iord;
    assign Ori         = ctrl_s.ori;
    assign MemWrite    = ctrl_s.memwrite;
    assign IRWrite     = ctrl_s.irwrite;
    assign RegWrite    = ctrl_s.regwrite;
    assign ALUSrcA     = ctrl_s.alusrca;
    assign ALUSrcB     = ctrl_s.alusrcb;
    assign PCSrc       = ctrl_s.pcsrc;
    assign RegDst      = ctrl_s.regdst;
    assign MemtoReg    = ctrl_s.memtoreg;
    assign ALUControl  = ctrl_s.aluctl;
    assign Jump        = ctrl_s.jump;
    assign illegal_o   = ctrl_s.illegal;
    assign instr_count = count_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed instructions,
// reset handling and a randomized instruction stream, checked every cycle
// against an instruction-level reference model.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        PCen, IorD, Ori, MemWrite, IRWrite, RegWrite, ALUSrcA, Jump, illegal_o;
    logic [1:0]  ALUSrcB, PCSrc, RegDst, MemtoReg;
    logic [2:0]  ALUControl;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       ori;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [2:0] aluctl;
        logic       jump;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    outs_t       obs;
    int          compared;
    int          mismatched;
    logic [31:0] exp_count;

    multicycle_control_unit #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCen(PCen), .IorD(IorD), .Ori(Ori), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUControl(ALUControl), .Jump(Jump),
        .illegal_o(illegal_o), .instr_count(instr_count), .state_o(state_o)
    );

    assign obs = {PCen, IorD, Ori, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
                  RegDst, MemtoReg, ALUControl, Jump, illegal_o, state_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Sequence of states an instruction walks through, four bits per step.
    function automatic int inst_path(input logic [5:0] o, input logic [5:0] f, output logic [19:0] p);
        int n;
        p = 20'h0;
        n = 2;
        p[3:0] = 4'd0; p[7:4] = 4'd1;
        case (o)
            6'b100011: begin p[11:8] = 4'd2; p[15:12] = 4'd3; p[19:16] = 4'd4; n = 5; end
            6'b101011: begin p[11:8] = 4'd2; p[15:12] = 4'd5; n = 4; end
            6'b000000: begin
                if (f == 6'b001000) begin
                    p[11:8] = 4'd14; n = 3;
                end else if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                             f == 6'b100101 || f == 6'b100111 || f == 6'b101010) begin
                    p[11:8] = 4'd6; p[15:12] = 4'd7; n = 4;
                end else begin
                    n = 2;
                end
            end
            6'b000100, 6'b000101: begin p[11:8] = 4'd8; n = 3; end
            6'b001000, 6'b001101: begin p[11:8] = 4'd9; p[15:12] = 4'd10; n = 4; end
            6'b111111: begin p[11:8] = 4'd11; p[15:12] = 4'd10; n = 4; end
            6'b000010: begin p[11:8] = 4'd12; n = 3; end
            6'b000011: begin p[11:8] = 4'd13; n = 3; end
            default: n = 2;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b100111: return 3'b100;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one step of the instruction (op, funct, zero).
    function automatic outs_t expect_for(input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic [3:0] st);
        outs_t e;
        logic [19:0] p;
        e = '0;
        e.state = st;
        case (st)
            4'd0: begin e.irwrite = 1'b1; e.alusrcb = 2'b01; e.aluctl = 3'b010; e.pcen = 1'b1; end
            4'd1: begin e.alusrcb = 2'b11; e.aluctl = 3'b010; e.illegal = (inst_path(o, f, p) == 2); end
            4'd2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
            4'd3: e.iord = 1'b1;
            4'd4: begin e.iord = 1'b1; e.memtoreg = 2'b01; e.regwrite = 1'b1; end
            4'd5: begin e.iord = 1'b1; e.memwrite = 1'b1; end
            4'd6: begin e.alusrca = 1'b1; e.aluctl = alu_of_funct(f); end
            4'd7: begin e.regdst = 2'b01; e.regwrite = 1'b1; end
            4'd8: begin
                e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
                e.pcen = (o == 6'b000100) ? z : ~z;
            end
            4'd9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = (o == 6'b001101) ? 3'b001 : 3'b010; end
            4'd10: e.regwrite = 1'b1;
            4'd11: begin e.ori = 1'b1; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
            4'd12: begin e.pcsrc = 2'b10; e.jump = 1'b1; e.pcen = 1'b1; end
            4'd13: begin
                e.pcsrc = 2'b10; e.jump = 1'b1; e.pcen = 1'b1;
                e.regdst = 2'b10; e.memtoreg = 2'b10; e.regwrite = 1'b1;
            end
            4'd14: begin e.pcsrc = 2'b11; e.pcen = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check_outs(input string tag, input outs_t exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag);
        compared++;
        assert (instr_count === exp_count) else begin
            mismatched++;
            $error("FAIL %s count: observed=%0d expected=%0d", tag, instr_count, exp_count);
        end
    endtask

    // Runs one instruction from FETCH; called just after a rising edge.
    // abort_at >= 0 asserts reset in that step and stops the instruction there.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int abort_at);
        logic [19:0] p;
        int n;
        outs_t masked;
        n = inst_path(o, f, p);
        op = o; funct = f; zero = z;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                masked = obs;
                masked.state = 4'd0;
                compared++;
                assert (masked === outs_t'(0)) else begin
                    mismatched++;
                    $error("FAIL %s reset-mid: observed=%h expected=0", tag, masked);
                end
                @(posedge clk); #1;
                reset = 1'b0;
                exp_count = 32'd0;
                return;
            end
            @(negedge clk);
            check_outs(tag, expect_for(o, f, z, p[4*k +: 4]));
            check_count(tag);
            @(posedge clk); #1;
        end
        if (n > 2) exp_count = exp_count + 32'd1;
    endtask

    logic [5:0] legal_ops [10];
    logic [5:0] legal_fn [7];

    initial begin
        compared = 0;
        mismatched = 0;
        exp_count = 32'd0;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b001000, 6'b001101, 6'b000010, 6'b000011, 6'b111111};
        legal_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                      6'b101010, 6'b001000};
        reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;

        // reset held: all controls zero, state FETCH, count zero
        repeat (3) begin
            @(negedge clk);
            check_outs("reset_hold", outs_t'(0));
            check_count("reset_hold");
            @(posedge clk); #1;
        end
        reset = 1'b0;

        run_instr("lw",        6'b100011, 6'b000000, 1'b0, -1);
        run_instr("r_sub",     6'b000000, 6'b100010, 1'b0, -1);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, -1);
        run_instr("beq_not",   6'b000100, 6'b000000, 1'b0, -1);
        run_instr("bne_taken", 6'b000101, 6'b000000, 1'b0, -1);
        run_instr("bne_not",   6'b000101, 6'b000000, 1'b1, -1);
        run_instr("jal",       6'b000011, 6'b000000, 1'b0, -1);
        run_instr("jr",        6'b000000, 6'b001000, 1'b0, -1);
        run_instr("illegal_op",6'b010101, 6'b000000, 1'b0, -1);
        run_instr("illegal_fn",6'b000000, 6'b111111, 1'b0, -1);
        run_instr("sw",        6'b101011, 6'b000000, 1'b0, -1);
        run_instr("addi",      6'b001000, 6'b000000, 1'b0, -1);
        run_instr("ori",       6'b001101, 6'b000000, 1'b0, -1);
        run_instr("in",        6'b111111, 6'b000000, 1'b0, -1);
        run_instr("j",         6'b000010, 6'b000000, 1'b0, -1);
        for (int i = 0; i < 7; i++) begin
            run_instr("r_funct", 6'b000000, legal_fn[i], 1'b0, -1);
        end

        // sw interrupted by reset in MEMADR: no write, counter cleared, restart at FETCH
        run_instr("sw_abort",  6'b101011, 6'b000000, 1'b0, 2);
        run_instr("after_abort", 6'b101011, 6'b000000, 1'b0, -1);

        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [5:0] ro, rf;
            if ($urandom_range(0, 9) == 0) ro = 6'($urandom_range(0, 63));
            else ro = legal_ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) rf = 6'($urandom_range(0, 63));
            else rf = legal_fn[$urandom_range(0, 6)];
            run_instr("random", ro, rf, 1'($urandom_range(0, 1)), -1);
        end

        // final count after the random stream
        @(negedge clk);
        check_count("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main-control FSM for the multicycle MIPS datapath.
- Consumes op, funct and zero from the datapath.
- Drives every datapath control strobe and mux select, one instruction step per clock.
- Also provides a retired-instruction counter, an illegal-opcode pulse and the state encoding for debug.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  instruction opcode, IR[31:26].
- funct  input  6  R-type function field, IR[5:0].
- zero  input  1  ALU zero flag (combinational, current cycle).
- PCen  output  1  PC register enable.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- Ori  output  1  immediate source select: 0 = IR[15:0], 1 = GPIO_i.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register enable.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B select: 00 = B register, 01 = 4, 10 = SignExt, 11 = SignExt<<2.
- PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = A register.
- RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = 31.
- MemtoReg  output  2  write data select: 00 = ALUOut, 01 = MemOut, 10 = PC.
- ALUControl  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
- Jump  output  1  jump-target override to the PC mux.
- illegal_o  output  1  one-cycle pulse on an undecoded op or funct.
- instr_count  output  CNT_WIDTH  number of instructions completed.
- state_o  output  4  current state encoding.

Behaviour:
- Reset and default outputs
  - reset=1 at a clock edge: state <= FETCH (0) and instr_count <= 0.
  - While reset=1, all control outputs are forced to 0 regardless of state.
  - Outputs not listed for a state are 0 in that state.
- Outputs are decoded from the current state. Exceptions:
  - PCen in BRANCH also depends on zero.
  - illegal_o in DECODE depends on op/funct.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, j 000010, jal 000011, in (GPIO read) 111111.
- R-type funct codes: add 100000 (ADD), sub 100010 (SUB), and 100100 (AND), or 100101 (OR), nor 100111 (NOR), slt 101010 (SLT), jr 001000.
- All immediates are sign-extended, including ori.
- States, their asserted outputs, and next state:
  - 0 FETCH: IRWrite=1, ALUSrcB=01, ALUControl=ADD, PCen=1. Next: DECODE.
  - 1 DECODE: ALUSrcB=11, ALUControl=ADD (branch target into ALUOut). Next by opcode:
    - lw/sw -> MEMADR
    - R with legal funct other than jr -> EXECUTE
    - R with jr -> JR
    - beq/bne -> BRANCH
    - addi/ori -> IMMEXEC
    - in -> GPIOEXEC
    - j -> JUMP
    - jal -> JAL
    - anything else -> FETCH, with illegal_o=1 for this cycle.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMREAD for lw, MEMWRITE for sw.
  - 3 MEMREAD: IorD=1. Next: MEMWB.
  - 4 MEMWB: IorD=1 (held; MemOut is unregistered), RegDst=00, MemtoReg=01, RegWrite=1. Next: FETCH.
  - 5 MEMWRITE: IorD=1, MemWrite=1. Next: FETCH.
  - 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct. Next: ALUWB.
  - 7 ALUWB: RegDst=01, MemtoReg=00, RegWrite=1. Next: FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01. PCen=zero for beq, PCen=~zero for bne. Next: FETCH.
  - 9 IMMEXEC: ALUSrcA=1, ALUSrcB=10, ADD for addi, OR for ori. Next: IMMWB.
  - 10 IMMWB: RegDst=00, MemtoReg=00, RegWrite=1. Next: FETCH.
  - 11 GPIOEXEC: Ori=1, ALUSrcA=1, ALUSrcB=10, ADD (rs is expected to be $0). Next: IMMWB.
  - 12 JUMP: PCSrc=10, Jump=1, PCen=1. Next: FETCH.
  - 13 JAL: PCSrc=10, Jump=1, PCen=1, RegDst=10, MemtoReg=10, RegWrite=1. Writes the pre-jump PC (already PC+4) to $31. Next: FETCH.
  - 14 JR: PCSrc=11, PCen=1. Next: FETCH.
  - 15 (unused): treated as FETCH on the next edge; all outputs 0.
- instr_count increments by 1 (wrapping at 2^CNT_WIDTH) on each transition into FETCH from any state other than FETCH, DECODE or reset. An illegal instruction is not counted.
- Cycle counts per instruction:
  - lw 5
  - sw, R-type, addi, ori, in 4
  - beq, bne, j, jal, jr 3
- Reset asserted mid-instruction:
  - Outputs go to 0 in that same cycle; no partial write may occur.
  - The FSM restarts at FETCH on the edge after reset is released.

Test Plan:
- Reset held 3 cycles, then released with op=100011 -> all outputs 0 during reset; after release, state_o sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=01 and IorD=1 only in state 4; instr_count=1.
- op=000000, funct=100010 -> states 0,1,6,7,0; ALUControl=110 in state 6; RegDst=01 with RegWrite=1 in state 7.
- op=000100 with zero=1, then again with zero=0 -> PCen=1 then PCen=0 in state 8, PCSrc=01 both times; op=000101 with zero=0 -> PCen=1.
- op=000011 -> state 13 asserts PCen=1, Jump=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1 in one cycle; op=000000, funct=001000 -> state 14 asserts PCSrc=11, PCen=1.
- op=010101 -> illegal_o=1 for 1 cycle in DECODE, next state FETCH, instr_count unchanged, no RegWrite or MemWrite asserted.
- op=101011 with reset pulsed during MEMADR -> MemWrite never asserts; the FSM returns to FETCH and instr_count reads 0.
